seg7_scan_display: RTL and testbench

Multiplexed eight-digit seven-segment driver that consumes the CPU's 32-bit LED/display word and scans it onto the Nexys 4 DDR common-anode display. It sits beside `MipsCPU_Top` in the board top level, taking `LedData_out` as its data source. Values are snapshotted only at frame boundaries so a digit scan never tears. Optional leading-zero blanking and a per-digit decimal-point mask are provided.

---
 rtl/seg7_pkg.sv | 17 +
 rtl/seg7_hex_decode.sv | 15 +
 rtl/seg7_scan_display.sv | 139 +++++++++++++
 tb/tb_seg7_scan_display.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan display: active-low segment
// codes for the hex digits and the "everything off" patterns.
package seg7_pkg;

    // Segment pattern with every segment dark (active-low, {g,f,e,d,c,b,a}).
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Anode pattern with every digit disabled (active-low).
    localparam logic [7:0] AN_OFF = 8'hFF;

    // Active-low segment codes for nibble values 0..F, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low seven-segment code lookup.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Straight table lookup; the table lives in the package so the
    // codes are defined in exactly one place.
    always_comb begin
        o_seg = HEX_SEG[i_nibble];
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Eight-digit multiplexed seven-segment driver for a common-anode display.
// The displayed word is snapshotted only at frame boundaries so a scan never
// shows a mix of old and new digits. Supports leading-zero blanking and a
// live per-digit decimal-point mask.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int CLK_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        load,
    input  logic        blank_en,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // True when nibbles n..7 of v are all zero (digit n is a leading zero).
    function automatic logic upper_nibbles_zero(input logic [31:0] v, input logic [2:0] n);
        logic [31:0] shifted;
        shifted = v >> {n, 2'b00};
        return (shifted == 32'd0);
    endfunction

    logic [DIV_W-1:0] r_div_cnt;
    logic [2:0]       r_idx;
    logic [31:0]      r_snap;
    logic [31:0]      r_shadow;
    logic             r_pending;
    logic [7:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;
    logic             r_frame_done;

    logic             w_tick;
    logic             w_boundary;
    logic [2:0]       w_next_idx;
    logic [31:0]      w_snap_next;
    logic [3:0]       w_nibble;
    logic [6:0]       w_seg_code;
    logic             w_blank;

    assign w_tick     = (r_div_cnt == DIV_LAST);
    assign w_boundary = w_tick && (r_idx == 3'd7);
    assign w_next_idx = r_idx + 3'd1;

    // Snapshot value as it will be after this cycle; the output stage decodes
    // this so a boundary tick shows the freshly captured word immediately.
    always_comb begin
        w_snap_next = r_snap;
        if (w_boundary) begin
            if (load) begin
                w_snap_next = data_in;
            end else if (r_pending) begin
                w_snap_next = r_shadow;
            end
        end
    end

    // Select the nibble for the digit about to be shown and decide blanking.
    always_comb begin
        w_nibble = w_snap_next[{w_next_idx, 2'b00} +: 4];
        w_blank  = blank_en && (w_next_idx != 3'd0)
                   && upper_nibbles_zero(w_snap_next, w_next_idx);
    end

    seg7_hex_decode u_hex_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_code)
    );

    // Slot divider and digit index; idx starts at 7 so the first tick is a frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_idx     <= 3'd7;
        end else if (w_tick) begin
            r_div_cnt <= '0;
            r_idx     <= w_next_idx;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Shadow capture between boundaries and snapshot transfer at the boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow  <= '0;
            r_snap    <= '0;
            r_pending <= 1'b0;
        end else begin
            r_snap <= w_snap_next;
            if (load) begin
                r_shadow <= data_in;
            end
            if (w_boundary) begin
                r_pending <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

    // Registered display outputs, refreshed on every tick for the new digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an         <= AN_OFF;
            r_seg        <= SEG_OFF;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_boundary;
            if (w_tick) begin
                if (w_blank) begin
                    r_an  <= AN_OFF;
                    r_seg <= SEG_OFF;
                    r_dp  <= 1'b1;
                end else begin
                    r_an  <= ~(8'd1 << w_next_idx);
                    r_seg <= w_seg_code;
                    r_dp  <= ~dp_mask[w_next_idx];
                end
            end
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Testbench for seg7_scan_display: table-driven digit checks, hand-written
// multi-cycle sequences, and randomized traffic against a cycle-count model.
module tb_seg7_scan_display;

    localparam int CLK_DIV = 4;
    localparam int FRAME   = 8 * CLK_DIV;

    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_in = 32'd0;
    logic        load = 1'b0;
    logic        blank_en = 1'b0;
    logic [7:0]  dp_mask = 8'h00;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int tests = 0;
    int fails = 0;

    // Reference model state: m_t counts clock edges since reset was released.
    int          m_t = 0;
    logic [31:0] m_snap = 0, m_shadow = 0;
    bit          m_pending = 0;
    logic [7:0]  m_an = 8'hFF;
    logic [6:0]  m_seg = 7'h7F;
    logic        m_dp = 1'b1;
    logic        m_fd = 1'b0;

    seg7_scan_display #(.CLK_DIV(CLK_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .load       (load),
        .blank_en   (blank_en),
        .dp_mask    (dp_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model one clock edge. Tick k (k = 0,1,..) happens on edge CLK_DIV*k+CLK_DIV-1
    // after reset and shows digit k mod 8; digit 0 ticks are frame boundaries.
    task automatic model_edge(input logic s_rst, input logic [31:0] s_data, input logic s_load,
                              input logic s_blank, input logic [7:0] s_dpm);
        bit tick, bnd, blank;
        int n;
        if (s_rst) begin
            m_t = 0; m_snap = 0; m_shadow = 0; m_pending = 0;
            m_an = 8'hFF; m_seg = 7'h7F; m_dp = 1'b1; m_fd = 1'b0;
        end else begin
            tick = ((m_t % CLK_DIV) == CLK_DIV - 1);
            n    = (m_t / CLK_DIV) % 8;
            bnd  = tick && (n == 0);
            if (bnd) begin
                if (s_load) m_snap = s_data;
                else if (m_pending) m_snap = m_shadow;
                m_pending = 0;
            end
            if (s_load) begin
                m_shadow = s_data;
                if (!bnd) m_pending = 1;
            end
            m_fd = bnd;
            if (tick) begin
                blank = s_blank && (n != 0) && ((m_snap >> (4 * n)) == 32'd0);
                if (blank) begin
                    m_an = 8'hFF; m_seg = 7'h7F; m_dp = 1'b1;
                end else begin
                    m_an  = ~(8'd1 << n);
                    m_seg = HEX[(m_snap >> (4 * n)) & 32'hF];
                    m_dp  = ~s_dpm[n];
                end
            end
            m_t++;
        end
    endtask

    // One clock: capture driven inputs, advance model at the edge, compare just after.
    task automatic cyc();
        logic s_rst, s_load, s_blank;
        logic [31:0] s_data;
        logic [7:0] s_dpm;
        s_rst = rst; s_load = load; s_blank = blank_en; s_data = data_in; s_dpm = dp_mask;
        @(posedge clk);
        model_edge(s_rst, s_data, s_load, s_blank, s_dpm);
        #1;
        check("model_an", 32'(an), 32'(m_an));
        check("model_seg", 32'(seg), 32'(m_seg));
        check("model_dp", 32'(dp), 32'(m_dp));
        check("model_frame_done", 32'(frame_done), 32'(m_fd));
    endtask

    task automatic do_reset();
        rst = 1'b1; load = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    // Advance until frame_done is seen, bounded to just over one frame.
    task automatic wait_frame(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < FRAME + 8 && !seen; i++) begin
            cyc();
            if (frame_done) seen = 1;
        end
        if (!seen) begin
            tests++; fails++;
            $display("FAIL %s: got no frame_done required pulse within %0d cycles", name, FRAME + 8);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic        blank;
        logic [7:0]  dpm;
        int          digit;
        logic [7:0]  exp_an;
        logic [6:0]  exp_seg;
        logic        exp_dp;
    } vec_t;

    vec_t vecs [12];
    logic [7:0] seq_an  [8];
    logic [6:0] seq_seg [8];

    initial begin
        int cnt, lat;

        vecs[0]  = '{32'h12345678, 1'b0, 8'h00, 0, 8'hFE, 7'h00, 1'b1};
        vecs[1]  = '{32'h12345678, 1'b0, 8'h00, 1, 8'hFD, 7'h78, 1'b1};
        vecs[2]  = '{32'h12345678, 1'b0, 8'h00, 2, 8'hFB, 7'h02, 1'b1};
        vecs[3]  = '{32'h12345678, 1'b0, 8'h00, 7, 8'h7F, 7'h79, 1'b1};
        vecs[4]  = '{32'h000000A5, 1'b1, 8'h00, 0, 8'hFE, 7'h12, 1'b1};
        vecs[5]  = '{32'h000000A5, 1'b1, 8'h00, 1, 8'hFD, 7'h08, 1'b1};
        vecs[6]  = '{32'h000000A5, 1'b1, 8'h00, 2, 8'hFF, 7'h7F, 1'b1};
        vecs[7]  = '{32'h000000A5, 1'b1, 8'h00, 7, 8'hFF, 7'h7F, 1'b1};
        vecs[8]  = '{32'h89ABCDEF, 1'b0, 8'h04, 2, 8'hFB, 7'h21, 1'b0};
        vecs[9]  = '{32'h89ABCDEF, 1'b0, 8'h04, 3, 8'hF7, 7'h46, 1'b1};
        vecs[10] = '{32'h00000000, 1'b1, 8'h00, 0, 8'hFE, 7'h40, 1'b1};
        vecs[11] = '{32'h00000000, 1'b1, 8'h00, 1, 8'hFF, 7'h7F, 1'b1};

        seq_an  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        seq_seg = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};

        // Reset state
        do_reset();
        check("reset_an", 32'(an), 32'hFF);
        check("reset_seg", 32'(seg), 32'h7F);
        check("reset_dp", 32'(dp), 32'd1);
        check("reset_frame_done", 32'(frame_done), 32'd0);

        // Table-driven digit checks: each vector loads once after reset,
        // waits for the first boundary, then steps to the requested digit slot.
        foreach (vecs[v]) begin
            do_reset();
            blank_en = vecs[v].blank; dp_mask = vecs[v].dpm;
            data_in = vecs[v].data; load = 1'b1;
            cyc();
            load = 1'b0;
            wait_frame("vec_frame");
            for (int i = 0; i < CLK_DIV * vecs[v].digit; i++) cyc();
            check($sformatf("vec%0d_an", v), 32'(an), 32'(vecs[v].exp_an));
            check($sformatf("vec%0d_seg", v), 32'(seg), 32'(vecs[v].exp_seg));
            check($sformatf("vec%0d_dp", v), 32'(dp), 32'(vecs[v].exp_dp));
        end

        // First-frame latency and scan order. Cycle 0 is the first cycle with
        // rst low; load is driven in cycle 1; digit 0 must appear in cycle CLK_DIV.
        blank_en = 1'b0; dp_mask = 8'h00;
        do_reset();
        cyc();
        data_in = 32'h12345678; load = 1'b1;
        cyc();
        load = 1'b0;
        lat = 2;
        while (an != 8'hFE && lat < 20) begin cyc(); lat++; end
        check("first_digit_cycle", 32'(lat), 32'(CLK_DIV));
        check("first_frame_done", 32'(frame_done), 32'd1);
        for (int d = 0; d < 8; d++) begin
            check($sformatf("scan_an_d%0d", d), 32'(an), 32'(seq_an[d]));
            check($sformatf("scan_seg_d%0d", d), 32'(seg), 32'(seq_seg[d]));
            for (int i = 0; i < CLK_DIV; i++) cyc();
        end
        check("frame_period_pulse", 32'(frame_done), 32'd1);
        cnt = 0;
        for (int i = 0; i < FRAME; i++) begin cyc(); if (frame_done) cnt++; end
        check("pulses_per_frame", 32'(cnt), 32'd1);
        check("frame_done_at_period", 32'(frame_done), 32'd1);

        // Two loads in one frame: the first is never shown.
        for (int i = 0; i < 3; i++) cyc();
        data_in = 32'h11111111; load = 1'b1; cyc(); load = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        data_in = 32'h22222222; load = 1'b1; cyc(); load = 1'b0;
        data_in = 32'h0;
        wait_frame("ab_frame");
        check("ab_boundary_seg", 32'(seg), 32'h24);
        cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (seg == 7'h79) cnt++;
            cyc();
        end
        check("ab_first_never_shown", 32'(cnt), 32'd0);

        // Load exactly in the boundary cycle (the cycle before frame_done rises).
        wait_frame("bnd_sync");
        for (int i = 0; i < FRAME - 1; i++) cyc();
        data_in = 32'h9ABCDEF0; load = 1'b1;
        cyc();
        load = 1'b0;
        check("bnd_load_frame_done", 32'(frame_done), 32'd1);
        check("bnd_load_an", 32'(an), 32'hFE);
        check("bnd_load_seg", 32'(seg), 32'h40);

        // Decimal point only in the digit-2 slot.
        wait_frame("dp_sync");
        dp_mask = 8'h04;
        cnt = 0; lat = 0;
        for (int i = 0; i < FRAME; i++) begin
            cyc();
            if (dp == 1'b0) cnt++;
            if (dp == 1'b0 && an != 8'hFB) lat++;
        end
        check("dp_low_cycles", 32'(cnt), 32'(CLK_DIV));
        check("dp_low_outside_digit2", 32'(lat), 32'd0);
        dp_mask = 8'h00;

        // Mid-frame reset with a load in the reset cycle (ignored).
        for (int i = 0; i < 10; i++) cyc();
        rst = 1'b1; data_in = 32'hFFFFFFFF; load = 1'b1;
        cyc();
        rst = 1'b0; load = 1'b0;
        check("midrst_an", 32'(an), 32'hFF);
        check("midrst_seg", 32'(seg), 32'h7F);
        check("midrst_dp", 32'(dp), 32'd1);
        cnt = 0;
        for (int i = 0; i < CLK_DIV - 1; i++) begin cyc(); if (an != 8'hFF) cnt++; end
        check("midrst_dark_cycles", 32'(cnt), 32'd0);
        cyc();
        check("midrst_restart_an", 32'(an), 32'hFE);
        check("midrst_restart_seg", 32'(seg), 32'h40);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            load = ($urandom_range(0, 7) == 0);
            data_in = ($urandom_range(0, 1) == 0) ? ($urandom() >> ($urandom_range(0, 7) * 4)) : $urandom();
            if ($urandom_range(0, 49) == 0) blank_en = ~blank_en;
            if ($urandom_range(0, 49) == 0) dp_mask = 8'($urandom());
            rst = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst = 1'b0; load = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
